// File: rtl/jump_sequencer_if.sv
// Handshake bundle between keyboard decode, jump_sequencer and the blocks datapath.
// master drives the requests, slave (the sequencer) drives the commands and layers.
interface jump_sequencer_if;
    logic        module_en;
    logic        one_ms_tick;
    logic        key_left;
    logic        key_right;
    logic        jump_fail;
    logic        jump_left;
    logic        jump_right;
    logic        load_layer;
    logic [0:6]  layer_map_out;
    logic [0:6]  block_type_out;
    logic        busy;
    logic [15:0] score;

    modport master (
        output module_en, one_ms_tick, key_left, key_right, jump_fail,
        input  jump_left, jump_right, load_layer,
        input  layer_map_out, block_type_out, busy, score
    );

    modport slave (
        input  module_en, one_ms_tick, key_left, key_right, jump_fail,
        output jump_left, jump_right, load_layer,
        output layer_map_out, block_type_out, busy, score
    );
endinterface

// File: rtl/jump_sequencer.sv
// Jump sequencer: initial layer fill, jump pulses with fresh layers, animation lockout.
// Optional score counter enabled by defining JUMP_SEQ_SCORE_EN.
module jump_sequencer #(
    parameter int unsigned ANIM_MS    = 200,
    parameter int unsigned NUM_LAYERS = 5,
    parameter int unsigned INIT_GAP   = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    jump_sequencer_if.slave bus
);

    localparam int CW = $clog2(ANIM_MS + 2);
    localparam int GW = $clog2(INIT_GAP + 1);
    localparam int FW = $clog2(NUM_LAYERS + 2);

    typedef enum logic [2:0] {
        IDLE, INIT, READY, JUMP, ANIM, FAIL
    } state_t;

    state_t        state, state_n;
    logic [15:0]   lfsr;
    logic          fb;
    logic [2:0]    pc, pc_n;
    logic [0:6]    map_q, type_q, map_n, type_n;
    logic          ld_q, jl_q, jr_q;
    logic          ld_n, jl_n, jr_n;
    logic          en_q;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gap, gap_n;
    logic [FW-1:0] fill, fill_n;
    logic          pend_v, pend_v_n;
    logic          pend_l, pend_l_n;
    logic          clr;
    logic          gen;
    logic          req;
    logic          anim_done;

    assign fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign req = bus.key_left ^ bus.key_right;
    assign gen = ld_n | jl_n | jr_n;

    assign anim_done = (cnt == '0) ||
                       (bus.one_ms_tick && cnt == CW'(1));

    // Next layer: path column walks one step, its block forced safe.
    always_comb begin
        if (pc == 3'd0)
            pc_n = 3'd1;
        else if (pc == 3'd6)
            pc_n = 3'd5;
        else if (lfsr[0])
            pc_n = pc - 3'd1;
        else
            pc_n = pc + 3'd1;
        map_n          = lfsr[7:1];
        map_n[pc_n]    = 1'b1;
        type_n         = lfsr[14:8];
        type_n[pc_n]   = 1'b1;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gap_n    = gap;
        fill_n   = fill;
        pend_v_n = pend_v;
        pend_l_n = pend_l;
        ld_n     = 1'b0;
        jl_n     = 1'b0;
        jr_n     = 1'b0;
        clr      = 1'b0;
        if (!bus.module_en) begin
            state_n  = IDLE;
            pend_v_n = 1'b0;
            clr      = 1'b1;
        end else if (state != IDLE && bus.jump_fail) begin
            state_n = FAIL;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!en_q) begin
                        state_n = INIT;
                        fill_n  = FW'(1);
                        gap_n   = '0;
                        ld_n    = 1'b1;
                    end
                end
                INIT: begin
                    if (fill == FW'(NUM_LAYERS)) begin
                        state_n = READY;
                    end else if (gap == GW'(INIT_GAP - 1)) begin
                        ld_n   = 1'b1;
                        fill_n = fill + 1'b1;
                        gap_n  = '0;
                    end else begin
                        gap_n = gap + 1'b1;
                    end
                end
                READY: begin
                    if (req) begin
                        state_n = JUMP;
                        jl_n    = bus.key_left;
                        jr_n    = bus.key_right;
                    end
                end
                JUMP: begin
                    state_n = ANIM;
                    cnt_n   = CW'(ANIM_MS);
                end
                ANIM: begin
                    if (bus.one_ms_tick && cnt != '0)
                        cnt_n = cnt - 1'b1;
                    if (anim_done) begin
                        if (pend_v) begin
                            state_n  = JUMP;
                            jl_n     = pend_l;
                            jr_n     = ~pend_l;
                            pend_v_n = 1'b0;
                        end else if (req) begin
                            state_n = JUMP;
                            jl_n    = bus.key_left;
                            jr_n    = bus.key_right;
                        end else begin
                            state_n = READY;
                        end
                    end else if (req && !pend_v) begin
                        pend_v_n = 1'b1;
                        pend_l_n = bus.key_left;
                    end
                end
                FAIL: begin
                    state_n = FAIL;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            lfsr   <= LFSR_SEED;
            pc     <= 3'd5;
            map_q  <= '0;
            type_q <= '0;
            ld_q   <= 1'b0;
            jl_q   <= 1'b0;
            jr_q   <= 1'b0;
            en_q   <= 1'b0;
            cnt    <= '0;
            gap    <= '0;
            fill   <= '0;
            pend_v <= 1'b0;
            pend_l <= 1'b0;
        end else begin
            state  <= state_n;
            en_q   <= bus.module_en;
            cnt    <= cnt_n;
            gap    <= gap_n;
            fill   <= fill_n;
            pend_v <= pend_v_n;
            pend_l <= pend_l_n;
            ld_q   <= ld_n;
            jl_q   <= jl_n;
            jr_q   <= jr_n;
            if (bus.module_en)
                lfsr <= {lfsr[14:0], fb};
            if (clr) begin
                map_q  <= '0;
                type_q <= '0;
            end else if (gen) begin
                pc     <= pc_n;
                map_q  <= map_n;
                type_q <= type_n;
            end
        end
    end

    assign bus.load_layer     = ld_q;
    assign bus.jump_left      = jl_q;
    assign bus.jump_right     = jr_q;
    assign bus.layer_map_out  = map_q;
    assign bus.block_type_out = type_q;
    // IDLE is quiescent like reset, so busy only covers active states.
    assign bus.busy = (state != READY) && (state != IDLE);

`ifdef JUMP_SEQ_SCORE_EN
    logic [15:0] score_q;
    logic        init_go;
    logic        scored;

    assign init_go = (state == IDLE) && bus.module_en && !en_q;
    assign scored  = (state == JUMP) && bus.module_en && !bus.jump_fail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            score_q <= '0;
        else if (init_go)
            score_q <= '0;
        else if (scored && score_q != 16'hFFFF)
            score_q <= score_q + 16'd1;
    end

    assign bus.score = score_q;
`else
    assign bus.score = 16'h0000;
`endif

endmodule

// File: tb/tb_jump_sequencer.sv
// Scoreboard bench for jump_sequencer: stimulus pushes expected pulses and layers,
// a negedge monitor pops and compares them; score checked with or without JUMP_SEQ_SCORE_EN.
module tb_jump_sequencer;

    localparam int          ANIM_MS    = 200;
    localparam int          NUM_LAYERS = 5;
    localparam int          INIT_GAP   = 4;
    localparam logic [15:0] SEED       = 16'hACE1;
`ifdef JUMP_SEQ_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    jump_sequencer_if bus ();

    jump_sequencer #(
        .ANIM_MS    (ANIM_MS),
        .NUM_LAYERS (NUM_LAYERS),
        .INIT_GAP   (INIT_GAP),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [0:6] map;
        logic [0:6] typ;
    } ev_t;

    ev_t         q[$];
    int          cyc       = 0;
    int          n_cmp     = 0;
    int          n_err     = 0;
    int          exp_score = 0;
    logic [15:0] m_lfsr    = SEED;
    int          m_pc      = 5;
    logic [2:0]  mon_k;
    ev_t         mon_e;

    // Polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int   taps[4] = '{16, 14, 13, 11};
        logic f = 1'b0;
        foreach (taps[i]) f = f ^ s[taps[i] - 1];
        return {s[14:0], f};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst)
            m_lfsr <= SEED;
        else if (bus.module_en)
            m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pulse generated at the coming clock edge from the current LFSR.
    task automatic push(input logic [2:0] kind, input bit counted);
        ev_t e;
        if (m_pc == 0)
            m_pc = 1;
        else if (m_pc == 6)
            m_pc = 5;
        else if (m_lfsr[0])
            m_pc = m_pc - 1;
        else
            m_pc = m_pc + 1;
        e.map       = m_lfsr[7:1];
        e.map[m_pc] = 1'b1;
        e.typ       = m_lfsr[14:8];
        e.typ[m_pc] = 1'b1;
        e.cyc       = cyc + 1;
        e.kind      = kind;
        q.push_back(e);
        if (counted) exp_score++;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                mon_e = q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missed_pulse: kind %b due cycle %0d not seen", mon_e.kind, mon_e.cyc);
            end
            mon_k = {bus.load_layer, bus.jump_left, bus.jump_right};
            if (mon_k != 3'b000) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: kind %b at cycle %0d, none required", mon_k, cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.kind != mon_k || mon_e.cyc != cyc ||
                        mon_e.map != bus.layer_map_out ||
                        mon_e.typ != bus.block_type_out) begin
                        n_err++;
                        $display("FAIL pulse: got kind=%b cyc=%0d map=%b type=%b, required kind=%b cyc=%0d map=%b type=%b",
                                 mon_k, cyc, bus.layer_map_out, bus.block_type_out,
                                 mon_e.kind, mon_e.cyc, mon_e.map, mon_e.typ);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_score(input string name);
        check(name, int'(bus.score), SCORE_EN ? exp_score : 0);
    endtask

    // Call in the cycle before the edge that sees the module_en rise.
    task automatic init_fill();
        exp_score = 0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            push(3'b100, 1'b0);
            repeat ((i == NUM_LAYERS - 1) ? 1 : INIT_GAP) step();
        end
        check("init_busy", int'(bus.busy), 1);
        step();
        check("init_done_busy", int'(bus.busy), 0);
        check_score("init_score");
    endtask

    task automatic do_jump(input bit left, input bit counted);
        bus.key_left  = left;
        bus.key_right = !left;
        push(left ? 3'b010 : 3'b001, counted);
        step();
        bus.key_left  = 1'b0;
        bus.key_right = 1'b0;
    endtask

    // Entered in the JUMP cycle; runs lockouts until the sequencer is READY.
    task automatic anim_chain(input bit keys_en, input bit force_lr);
        bit         pv;
        bit         pl;
        bit         again;
        bit         frc;
        logic [1:0] k;
        int         n;
        again = 1'b1;
        frc   = force_lr;
        while (again) begin
            step();
            pv = 1'b0;
            pl = 1'b0;
            if (frc) begin
                bus.key_left = 1'b1;
                step();
                bus.key_left  = 1'b0;
                bus.key_right = 1'b1;
                step();
                bus.key_right = 1'b0;
                pv  = 1'b1;
                pl  = 1'b1;
                frc = 1'b0;
            end
            for (int t = 1; t <= ANIM_MS; t++) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    if (keys_en && $urandom_range(0, 15) == 0) begin
                        k = 2'($urandom_range(1, 3));
                        bus.key_left  = k[1];
                        bus.key_right = k[0];
                        if (!pv && k != 2'b11) begin
                            pv = 1'b1;
                            pl = k[1];
                        end
                    end
                    step();
                    bus.key_left  = 1'b0;
                    bus.key_right = 1'b0;
                end
                if (t == ANIM_MS) begin
                    check("anim_busy", int'(bus.busy), 1);
                    if (pv) push(pl ? 3'b010 : 3'b001, 1'b1);
                end
                bus.one_ms_tick = 1'b1;
                step();
                bus.one_ms_tick = 1'b0;
            end
            check("anim_end_busy", int'(bus.busy), int'(pv));
            again = pv;
        end
    endtask

    initial begin
        bus.module_en   = 1'b0;
        bus.one_ms_tick = 1'b0;
        bus.key_left    = 1'b0;
        bus.key_right   = 1'b0;
        bus.jump_fail   = 1'b0;
        repeat (3) step();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_load", int'(bus.load_layer), 0);
        check("rst_jl", int'(bus.jump_left), 0);
        check("rst_jr", int'(bus.jump_right), 0);
        check("rst_map", int'(bus.layer_map_out), 0);
        check("rst_type", int'(bus.block_type_out), 0);
        check("rst_score", int'(bus.score), 0);

        bus.module_en = 1'b1;
        step();
        rst = 1'b1;
        init_fill();

        do_jump(1'b0, 1'b1);
        anim_chain(1'b0, 1'b0);
        check_score("score_one");

        do_jump(1'b0, 1'b1);
        anim_chain(1'b0, 1'b1);

        bus.key_left  = 1'b1;
        bus.key_right = 1'b1;
        step();
        bus.key_left  = 1'b0;
        bus.key_right = 1'b0;
        repeat (3) step();
        check("both_keys_ready", int'(bus.busy), 0);

        repeat (4) begin
            do_jump(1'($urandom_range(0, 1)), 1'b1);
            anim_chain(1'b1, 1'b0);
        end
        check_score("score_random");

        do_jump(1'b1, 1'b1);
        step();
        bus.key_right = 1'b1;
        step();
        bus.key_right = 1'b0;
        repeat (10) begin
            bus.one_ms_tick = 1'b1;
            step();
            bus.one_ms_tick = 1'b0;
        end
        bus.jump_fail = 1'b1;
        step();
        bus.jump_fail = 1'b0;
        repeat (ANIM_MS + 20) begin
            bus.one_ms_tick = 1'b1;
            bus.key_left    = ($urandom_range(0, 7) == 0);
            step();
            bus.one_ms_tick = 1'b0;
            bus.key_left    = 1'b0;
        end
        check("fail_busy", int'(bus.busy), 1);
        check_score("fail_score");
        bus.module_en = 1'b0;
        step();
        check("idle_busy", int'(bus.busy), 0);
        check("idle_map", int'(bus.layer_map_out), 0);
        check_score("idle_score");
        bus.module_en = 1'b1;
        init_fill();

        repeat (3) begin
            do_jump(1'($urandom_range(0, 1)), 1'b1);
            anim_chain(1'b0, 1'b0);
        end
        bus.key_left = 1'b1;
        push(3'b010, 1'b0);
        step();
        bus.key_left  = 1'b0;
        bus.jump_fail = 1'b1;
        step();
        bus.jump_fail = 1'b0;
        repeat (5) step();
        check_score("score_fail_hold");
        check("score_fail_busy", int'(bus.busy), 1);
        bus.key_right = 1'b1;
        step();
        bus.key_right = 1'b0;
        bus.module_en = 1'b0;
        step();
        check_score("score_idle_hold");

        bus.module_en = 1'b1;
        exp_score = 0;
        push(3'b100, 1'b0);
        step();
        step();
        rst = 1'b0;
        m_pc = 5;
        exp_score = 0;
        #1;
        check("arst_load", int'(bus.load_layer), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_map", int'(bus.layer_map_out), 0);
        check("arst_type", int'(bus.block_type_out), 0);
        check("arst_score", int'(bus.score), 0);
        repeat (2) step();
        rst = 1'b1;
        init_fill();
        do_jump(1'b1, 1'b1);
        anim_chain(1'b0, 1'b0);
        check_score("score_final");

        repeat (5) step();
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
